// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: sequencing states, framebuffer
// geometry defaults derived from the VGA pixel scale, and a saturating counter helper.
package frame_scheduler_pkg;

   localparam int PIXEL_SCALE   = 5;
   localparam int H_PIX_DEFAULT = 640 / PIXEL_SCALE;
   localparam int V_PIX_DEFAULT = 480 / PIXEL_SCALE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RENDER,
      ST_DRAIN,
      ST_DONE
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/frame_scheduler_edge.sv
// Frame boundary detector: registers vsync and flags its 1->0 transition
// as a one-cycle pulse, valid the cycle after the falling sample.
module frame_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   output logic fall_edge
);

   logic vsync_q;
   logic fall_q;
   logic fall_d;

   assign fall_d = vsync_q & ~vsync;

   // vsync_q clears to 0 so a low vsync at reset release is not taken as an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         fall_q  <= fall_d;
      end
   end

   assign fall_edge = fall_q;

endmodule

// File: rtl/frame_scheduler.sv
// Frame-locked sequencer: ticks the game once per frame, sweeps the hidden
// framebuffer half through the renderer, and swaps buffers at the next frame edge.
module frame_scheduler
   import frame_scheduler_pkg::*;
#(
   parameter int H_PIX  = H_PIX_DEFAULT,
   parameter int V_PIX  = V_PIX_DEFAULT,
   parameter int ADDR_W = 14,
   parameter int SETTLE = 4,
   parameter int LAT    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              pause,
   output logic [6:0]        render_x,
   output logic [6:0]        render_y,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_en,
   output logic              buffer_sel,
   output logic              game_tick,
   output logic              busy,
   output logic              overrun,
   output logic [15:0]       frame_count,
   output logic [7:0]        overrun_count
);

   localparam logic [6:0] X_LAST   = 7'(H_PIX - 1);
   localparam logic [6:0] Y_LAST   = 7'(V_PIX - 1);
   localparam logic [3:0] SETTLE_C = 4'(SETTLE);
   localparam logic [3:0] LAT_C    = 4'(LAT);

   logic frame_edge;

   frame_edge_detect u_edge (
      .clk       (clk),
      .reset     (reset),
      .vsync     (vsync),
      .fall_edge (frame_edge)
   );

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [6:0]          render_x_q, render_x_d;
   logic [6:0]          render_y_q, render_y_d;
   logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
   logic                buffer_sel_q, buffer_sel_d;
   logic                game_tick_q, game_tick_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic [15:0]         frame_count_q, frame_count_d;
   logic [7:0]          overrun_count_q, overrun_count_d;
   logic                issue;

   assign issue = (state_q == ST_RENDER);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      render_x_d      = render_x_q;
      render_y_d      = render_y_q;
      pix_addr_d      = pix_addr_q;
      buffer_sel_d    = buffer_sel_q;
      game_tick_d     = 1'b0;
      overrun_d       = 1'b0;
      frame_count_d   = frame_count_q;
      overrun_count_d = overrun_count_q;

      case (state_q)
         ST_IDLE: begin
            if (frame_edge) begin
               game_tick_d = ~pause;
               cnt_d       = 4'd0;
               state_d     = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_C) begin
               render_x_d = 7'd0;
               render_y_d = 7'd0;
               pix_addr_d = '0;
               state_d    = ST_RENDER;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RENDER: begin
            // The last pixel leaves x/y/address parked on the final coordinate
            if (render_x_q == X_LAST && render_y_q == Y_LAST) begin
               cnt_d   = 4'd1;
               state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
            end else if (render_x_q == X_LAST) begin
               render_x_d = 7'd0;
               render_y_d = render_y_q + 7'd1;
               pix_addr_d = pix_addr_q + 1'b1;
            end else begin
               render_x_d = render_x_q + 7'd1;
               pix_addr_d = pix_addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == LAT_C) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (frame_edge) begin
               buffer_sel_d  = ~buffer_sel_q;
               frame_count_d = frame_count_q + 16'd1;
               game_tick_d   = ~pause;
               cnt_d         = 4'd0;
               state_d       = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A frame edge while still rendering is lost: no tick, no swap
      if (frame_edge && (state_q inside {ST_SETTLE, ST_RENDER, ST_DRAIN})) begin
         overrun_d       = 1'b1;
         overrun_count_d = sat_inc8(overrun_count_q);
      end

      busy_d = (state_d inside {ST_SETTLE, ST_RENDER, ST_DRAIN});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         cnt_q           <= 4'd0;
         render_x_q      <= 7'd0;
         render_y_q      <= 7'd0;
         pix_addr_q      <= '0;
         buffer_sel_q    <= 1'b0;
         game_tick_q     <= 1'b0;
         busy_q          <= 1'b0;
         overrun_q       <= 1'b0;
         frame_count_q   <= 16'd0;
         overrun_count_q <= 8'd0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         render_x_q      <= render_x_d;
         render_y_q      <= render_y_d;
         pix_addr_q      <= pix_addr_d;
         buffer_sel_q    <= buffer_sel_d;
         game_tick_q     <= game_tick_d;
         busy_q          <= busy_d;
         overrun_q       <= overrun_d;
         frame_count_q   <= frame_count_d;
         overrun_count_q <= overrun_count_d;
      end
   end

   generate
      if (LAT == 0) begin : g_no_lat
         assign wr_en   = issue;
         assign wr_addr = pix_addr_q;
      end else begin : g_lat
         logic [LAT-1:0]    en_dly_q;
         logic [ADDR_W-1:0] addr_dly_q [LAT];

         // Write strobe and address follow the graphics pipeline depth
         always_ff @(posedge clk) begin
            if (reset) begin
               en_dly_q <= '0;
               for (int i = 0; i < LAT; i++) addr_dly_q[i] <= '0;
            end else begin
               en_dly_q[0]   <= issue;
               addr_dly_q[0] <= pix_addr_q;
               for (int i = 1; i < LAT; i++) begin
                  en_dly_q[i]   <= en_dly_q[i-1];
                  addr_dly_q[i] <= addr_dly_q[i-1];
               end
            end
         end

         assign wr_en   = en_dly_q[LAT-1];
         assign wr_addr = addr_dly_q[LAT-1];
      end
   endgenerate

   assign render_x      = render_x_q;
   assign render_y      = render_y_q;
   assign buffer_sel    = buffer_sel_q;
   assign game_tick     = game_tick_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;
   assign frame_count   = frame_count_q;
   assign overrun_count = overrun_count_q;

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences each video frame of the game: detects the start of vertical sync, issues the one-cycle game tick that advances players, fireballs and the game handler, then sweeps the off-screen half of the ping-pong frame buffer pixel-by-pixel through the graphics block and swaps buffers at the next frame boundary. It sits between the VGA timing generator, the graphics renderer and the ping-pong RAM, and it replaces the free-running player clock with a frame-locked tick plus an explicit buffer select.

## Interface
Parameters:
- H_PIX, 128: framebuffer width in pixels (640/5).
- V_PIX, 96: framebuffer height in pixels (480/5).
- ADDR_W, 14: write-address width; must satisfy H_PIX*V_PIX-1 < 2**ADDR_W.
- SETTLE, 4: idle cycles between game_tick and first render pixel (1..15).
- LAT, 0: graphics pipeline latency in cycles (0..3); write strobe/address delayed by LAT.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- vsync  in  1  active-low VGA vsync, synchronous to clk.
- pause  in  1  suppresses game_tick while high; rendering and swaps continue.
- render_x  out  7  pixel column presented to graphics.
- render_y  out  7  pixel row presented to graphics.
- wr_addr  out  ADDR_W  frame-buffer write address (render_y*H_PIX+render_x, delayed LAT).
- wr_en  out  1  write strobe for wr_addr, delayed LAT.
- buffer_sel  out  1  which RAM half is displayed; the other is written.
- game_tick  out  1  one-cycle pulse advancing game state.
- busy  out  1  high in SETTLE or RENDER or while the write pipeline drains.
- overrun  out  1  one-cycle pulse when a frame edge arrives before rendering completes.
- frame_count  out  16  completed (swapped) frames, wraps.
- overrun_count  out  8  overruns, saturates at 255.

## Operation
- Frame edge: vsync 1->0 detected with a registered copy of vsync; edge flag valid the cycle after the falling sample.
- States: IDLE, SETTLE, RENDER, DRAIN, DONE.
- IDLE (after reset): on edge -> game_tick (unless pause), no swap, -> SETTLE.
- SETTLE: counts SETTLE cycles, then -> RENDER with render_x=render_y=0.
- RENDER: one pixel per cycle, x fastest; x wraps at H_PIX-1 and increments y; after (H_PIX-1, V_PIX-1) -> DRAIN.
- DRAIN: holds LAT cycles until last wr_en retires (zero cycles when LAT=0), then -> DONE.
- DONE: on edge -> toggle buffer_sel, frame_count+1, game_tick (unless pause), -> SETTLE.
- Edge in SETTLE, RENDER or DRAIN: overrun pulse, overrun_count+1 (saturating), no swap, no tick; current sweep continues; the next edge in DONE swaps normally.
- pause high at an edge in DONE: swap and frame_count still occur; only game_tick is masked.
- render_x/render_y hold last value outside RENDER; wr_en low outside the delayed RENDER window.

## Timing
- Reset values: state IDLE, buffer_sel 0, game_tick 0, wr_en 0, wr_addr 0, render_x/y 0, busy 0, overrun 0, both counters 0; LAT pipeline cleared.
- Reset mid-RENDER: next cycle all outputs at reset values; partial frame discarded, no swap.
- Edge-to-tick: game_tick high exactly one cycle, the cycle after the edge flag; buffer_sel toggles same cycle.
- First render pixel: SETTLE+1 cycles after game_tick.
- wr_en asserted for exactly H_PIX*V_PIX cycles per frame, contiguous, addresses 0..H_PIX*V_PIX-1 ascending; wr_en at cycle n+LAT for pixel issued at cycle n.
- Render time 12288+SETTLE+LAT+1 cycles at defaults, well inside one 420,000-cycle frame.

## Structure
- Shared game package: state enum, H_PIX/V_PIX defaults, pixel-scale constant (5).
- One sub-module: frame_edge_detect (registered vsync, falling-edge pulse); LAT pipeline inline.

## Test plan
- Reset then hold: all outputs at reset values; no tick without vsync edge.
- H_PIX=4, V_PIX=3, SETTLE=2, LAT=0: edge -> tick, 2 idle cycles, wr_addr 0..11 on 12 consecutive cycles, DONE; second edge -> buffer_sel=1, frame_count=1.
- LAT=2: wr_addr/wr_en lag render_x/render_y by exactly 2 cycles; busy drops 2 cycles after last pixel issued.
- Edge at render pixel 5: overrun pulse, overrun_count=1, buffer_sel unchanged, sweep completes; next edge swaps.
- pause=1 across two frames: no game_tick, buffer_sel still toggles, frame_count increments.
- reset asserted at pixel 7: next cycle wr_en=0, state IDLE; next edge produces tick with no swap.
